// File: rtl/uart_rx_param_if.sv
// Received-word handshake bundle for uart_rx_param: data word with valid/ready.
// The receiver drives the master side; the downstream consumer uses the slave side.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] out;
    logic                 out_valid;
    logic                 out_ready;

    modport master (output out, output out_valid, input out_ready);
    modport slave  (input out, input out_valid, output out_ready);
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with a one-word valid/ready holding register.
// Define UART_RX_MAJORITY_EN to take each bit as a 3-sample majority vote around mid-bit.
//
// state   | meaning
// S_IDLE  | waiting for a synchronised falling edge
// S_START | checking the start bit at mid-bit (false-start filter)
// S_DATA  | sampling data bits LSB first, one per bit period
// S_PARITY| sampling and checking the parity bit
// S_STOP  | sampling stop bit(s), then delivering or discarding the word
module uart_rx_param #(
    parameter int CLK_PER_BIT = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 info,
    uart_rx_param_if.master      bus,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW  = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int MID = CLK_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // With voting the decision lands one count after mid so that the third sample exists;
    // the counter is re-phased by the same amount so bit spacing stays CLK_PER_BIT.
    localparam logic [CW-1:0] C_LAST      = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] C_START_DEC = CW'(MID + MAJ);
    localparam logic [CW-1:0] C_BIT_DEC   = (MAJ != 0) ? '0 : C_LAST;
    localparam logic [CW-1:0] C_RELOAD    = CW'(MAJ);
    localparam logic [3:0]    C_IDX_LAST  = 4'(DATA_BITS - 1);
    localparam logic          C_STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_lat;
    logic [DATA_BITS-1:0] r_out;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;
    logic                 r_busy;

    logic r_sync1, r_sync2, r_sync3;
`ifdef UART_RX_MAJORITY_EN
    logic r_sync4;
`endif

    logic          w_fall;
    logic          w_bit;
    logic          w_par_exp;
    logic [CW-1:0] w_cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            r_sync4 <= 1'b1;
`endif
        end else begin
            r_sync1 <= info;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
`ifdef UART_RX_MAJORITY_EN
            r_sync4 <= r_sync3;
`endif
        end
    end

    assign w_fall = r_sync3 & ~r_sync2;

`ifdef UART_RX_MAJORITY_EN
    assign w_bit = (r_sync4 & r_sync3) | (r_sync4 & r_sync2) | (r_sync3 & r_sync2);
`else
    assign w_bit = r_sync2;
`endif

    assign w_par_exp  = (PARITY_MODE == 2) ? ~(^r_shift) : (^r_shift);
    assign w_cnt_next = (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_shift      <= '0;
            r_par_lat    <= 1'b0;
            r_out        <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            if (r_valid && bus.out_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_cnt == C_START_DEC) begin
                        if (!w_bit) begin
                            r_state   <= S_DATA;
                            r_cnt     <= C_RELOAD;
                            r_bit_idx <= '0;
                            r_par_lat <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end

                S_DATA: begin
                    r_cnt <= w_cnt_next;
                    if (r_cnt == C_BIT_DEC) begin
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == C_IDX_LAST) begin
                            r_state    <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                            r_stop_idx <= 1'b0;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end

                S_PARITY: begin
                    r_cnt <= w_cnt_next;
                    if (r_cnt == C_BIT_DEC) begin
                        if (w_bit != w_par_exp) begin
                            r_par_lat <= 1'b1;
                        end
                        r_state    <= S_STOP;
                        r_stop_idx <= 1'b0;
                    end
                end

                S_STOP: begin
                    r_cnt <= w_cnt_next;
                    if (r_cnt == C_BIT_DEC) begin
                        if (!w_bit) begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                        end else if (r_stop_idx == C_STOP_LAST) begin
                            // Old word is kept on overrun unless it is consumed this same cycle.
                            if (!r_valid || bus.out_ready) begin
                                r_out   <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                            r_parity_err <= r_par_lat;
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_valid;
    assign frame_err     = r_frame_err;
    assign parity_err    = r_parity_err;
    assign overrun       = r_overrun;
    assign busy          = r_busy;

endmodule
